// File: rtl/video_src_scheduler_pkg.sv
// Shared definitions for the video source scheduler: grant state encoding,
// round-robin index width and black-level constants.
package video_src_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  localparam logic [31:0] BLACK_R = 32'h0000_0000;
  localparam logic [31:0] BLACK_G = 32'h0000_0000;
  localparam logic [31:0] BLACK_B = 32'h0000_0000;

  function automatic int rr_idx_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_src_scheduler_rr_pick.sv
// Combinational round-robin finder: first set request strictly after 'last',
// wrapping modulo NUM_SRC (so 'last' itself is the final candidate).
module rr_pick
  import video_src_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = rr_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    next_id,
  output logic               found
);

  localparam logic [ID_W:0] NUM_L = (ID_W+1)'(NUM_SRC);

  // Scan farthest candidate first so the nearest requester wins last.
  always_comb begin : search
    logic [ID_W:0]   sum_v;
    logic [ID_W-1:0] idx_v;
    next_id = '0;
    found   = 1'b0;
    sum_v   = '0;
    idx_v   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      sum_v   = {1'b0, last} + (ID_W+1)'(k);
      idx_v   = (sum_v >= NUM_L) ? ID_W'(sum_v - NUM_L) : sum_v[ID_W-1:0];
      next_id = req[idx_v] ? idx_v : next_id;
      found   = found | req[idx_v];
    end
  end

endmodule

// File: rtl/video_src_scheduler.sv
// Frame-synchronous round-robin video source scheduler with minimum dwell
// and a single registered output stage.
module video_src_scheduler
  import video_src_scheduler_pkg::*;
#(
  parameter int  NUM_SRC = 4,
  parameter int  DATA_W  = 8,
  parameter int  CNT_W   = 8,
  localparam int ID_W    = rr_idx_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_hs,
  input  logic [NUM_SRC-1:0]        src_vs,
  input  logic [NUM_SRC-1:0]        src_de,
  input  logic [NUM_SRC*DATA_W-1:0] src_rgb_r,
  input  logic [NUM_SRC*DATA_W-1:0] src_rgb_g,
  input  logic [NUM_SRC*DATA_W-1:0] src_rgb_b,
  input  logic [CNT_W-1:0]          dwell_cfg,
  output logic                      hs,
  output logic                      vs,
  output logic                      de,
  output logic [DATA_W-1:0]         rgb_r,
  output logic [DATA_W-1:0]         rgb_g,
  output logic [DATA_W-1:0]         rgb_b,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      switch_pulse
);

  sched_state_e      state_r, state_s;
  logic [ID_W-1:0]   last_id_r, last_id_s, pick_id_s;
  logic              pick_found_s;
  logic [CNT_W-1:0]  frame_cnt_r, frame_cnt_s, dwell_r, dwell_s;
  logic [CNT_W:0]    cnt_inc_s, dwell_eff_s;
  logic              vs_d_r, armed_r, ref_vs_s, boundary_s, dwell_met_s, grant_new_s;
  logic              hold_next_s;
  logic [DATA_W-1:0] pix_r_s, pix_g_s, pix_b_s;

  // last_id doubles as the current owner while in HOLD.
  assign ref_vs_s    = (state_r == ST_HOLD) ? src_vs[last_id_r] : src_vs[0];
  // armed_r blocks a boundary until vsync has been seen low after reset.
  assign boundary_s  = ref_vs_s & ~vs_d_r & armed_r;
  assign cnt_inc_s   = {1'b0, frame_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign dwell_eff_s = (dwell_r == {CNT_W{1'b0}}) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, dwell_r};
  assign dwell_met_s = (cnt_inc_s >= dwell_eff_s);
  assign hold_next_s = (state_s == ST_HOLD);

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (src_req),
    .last    (last_id_r),
    .next_id (pick_id_s),
    .found   (pick_found_s)
  );

  // Next-state and grant decision, evaluated only on frame boundaries.
  always_comb begin
    state_s     = state_r;
    last_id_s   = last_id_r;
    frame_cnt_s = frame_cnt_r;
    dwell_s     = dwell_r;
    grant_new_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (boundary_s && pick_found_s) grant_new_s = 1'b1;
        else                            grant_new_s = 1'b0;
      end
      ST_HOLD: begin
        if (!boundary_s) begin
          frame_cnt_s = frame_cnt_r;
        end else if (!src_req[last_id_r]) begin
          if (pick_found_s) grant_new_s = 1'b1;
          else              state_s     = ST_IDLE;
        end else if (dwell_met_s && (pick_id_s != last_id_r)) begin
          grant_new_s = 1'b1;
        end else begin
          frame_cnt_s = (&frame_cnt_r) ? frame_cnt_r : cnt_inc_s[CNT_W-1:0];
        end
      end
      default: state_s = ST_IDLE;
    endcase
    if (grant_new_s) begin
      state_s     = ST_HOLD;
      last_id_s   = pick_id_s;
      frame_cnt_s = '0;
      dwell_s     = dwell_cfg;
    end else begin
      dwell_s     = dwell_r;
    end
  end

  // Colour mux driven by the post-update grant.
  always_comb begin
    pix_r_s = '0;
    pix_g_s = '0;
    pix_b_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pix_r_s = (last_id_s == ID_W'(i)) ? src_rgb_r[i*DATA_W +: DATA_W] : pix_r_s;
      pix_g_s = (last_id_s == ID_W'(i)) ? src_rgb_g[i*DATA_W +: DATA_W] : pix_g_s;
      pix_b_s = (last_id_s == ID_W'(i)) ? src_rgb_b[i*DATA_W +: DATA_W] : pix_b_s;
    end
  end

  // Scheduler state and vsync history.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_r     <= ST_IDLE;
      last_id_r   <= ID_W'(NUM_SRC - 1);
      frame_cnt_r <= '0;
      dwell_r     <= '0;
      vs_d_r      <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_id_r   <= last_id_s;
      frame_cnt_r <= frame_cnt_s;
      dwell_r     <= dwell_s;
      vs_d_r      <= ref_vs_s;
      armed_r     <= armed_r | ~ref_vs_s;
    end
  end

  // Output register stage: datapath and grant status move together.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      switch_pulse <= 1'b0;
      hs           <= 1'b0;
      vs           <= 1'b0;
      de           <= 1'b0;
      rgb_r        <= '0;
      rgb_g        <= '0;
      rgb_b        <= '0;
    end else begin
      grant_valid  <= hold_next_s;
      grant_id     <= hold_next_s ? last_id_s : '0;
      switch_pulse <= (state_s != state_r) || (hold_next_s && (last_id_s != last_id_r));
      if (hold_next_s) begin
        hs    <= src_hs[last_id_s];
        vs    <= src_vs[last_id_s];
        de    <= src_de[last_id_s];
        rgb_r <= src_de[last_id_s] ? pix_r_s : BLACK_R[DATA_W-1:0];
        rgb_g <= src_de[last_id_s] ? pix_g_s : BLACK_G[DATA_W-1:0];
        rgb_b <= src_de[last_id_s] ? pix_b_s : BLACK_B[DATA_W-1:0];
      end else begin
        hs    <= src_hs[0];
        vs    <= src_vs[0];
        de    <= 1'b0;
        rgb_r <= BLACK_R[DATA_W-1:0];
        rgb_g <= BLACK_G[DATA_W-1:0];
        rgb_b <= BLACK_B[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_video_src_scheduler.sv
// Bench for video_src_scheduler: shared synthetic video timing, random pixels,
// scenario tasks plus a frame-level reference model of the grant rules.
module tb_video_src_scheduler;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int ID_W    = 2;
  localparam int H_TOT   = 12;
  localparam int V_TOT   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      arstn = 1'b0;
  logic [NUM_SRC-1:0]        src_req = '0;
  logic [NUM_SRC-1:0]        src_hs, src_vs, src_de;
  logic [NUM_SRC*DATA_W-1:0] src_rgb_r, src_rgb_g, src_rgb_b;
  logic [CNT_W-1:0]          dwell_cfg = '0;
  logic                      hs, vs, de, grant_valid, switch_pulse;
  logic [DATA_W-1:0]         rgb_r, rgb_g, rgb_b;
  logic [ID_W-1:0]           grant_id;

  logic [30:0] obs, exp_vec;
  assign obs = {grant_valid, grant_id, switch_pulse, hs, vs, de, rgb_r, rgb_g, rgb_b};

  int n_vec = 0, n_bad = 0;
  int hcnt = H_TOT - 1, vcnt = V_TOT - 1;
  bit vs_rise = 1'b0, tb_prev_vs = 1'b0;
  int m_hold = 0, m_id = NUM_SRC - 1, m_frames = 0, m_dwell = 0, m_prev = 0, m_armed = 0;

  video_src_scheduler #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .arstn(arstn), .src_req(src_req),
    .src_hs(src_hs), .src_vs(src_vs), .src_de(src_de),
    .src_rgb_r(src_rgb_r), .src_rgb_g(src_rgb_g), .src_rgb_b(src_rgb_b),
    .dwell_cfg(dwell_cfg), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .grant_valid(grant_valid), .grant_id(grant_id), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  function automatic int find_next(input logic [NUM_SRC-1:0] req, input int after);
    for (int k = 1; k <= NUM_SRC; k++)
      if (req[2'((after + k) % NUM_SRC)]) return (after + k) % NUM_SRC;
    return -1;
  endfunction

  task automatic drive_timing();
    hcnt++;
    if (hcnt == H_TOT) begin
      hcnt = 0;
      vcnt = (vcnt + 1) % V_TOT;
    end
    src_hs    = {NUM_SRC{hcnt < 2}};
    src_vs    = {NUM_SRC{vcnt == 0}};
    src_de    = {NUM_SRC{(vcnt != 0) && (hcnt >= 3) && (hcnt < 11)}};
    src_rgb_r = $urandom;
    src_rgb_g = $urandom;
    src_rgb_b = $urandom;
  endtask

  // Reference model: what the outputs must be after this clock edge.
  task automatic model_update();
    int old_hold, old_id, nxt, dw, s;
    logic ref_v, bnd, pulse, d;
    logic [7:0] er, eg, eb;
    if (!arstn) begin
      m_hold = 0; m_id = NUM_SRC - 1; m_frames = 0; m_prev = 0; m_armed = 0;
      exp_vec = '0;
      return;
    end
    old_hold = m_hold;
    old_id   = m_id;
    ref_v = (m_hold != 0) ? src_vs[2'(m_id)] : src_vs[0];
    bnd   = ref_v && (m_prev == 0) && (m_armed != 0);
    m_prev = ref_v;
    if (!ref_v) m_armed = 1;
    if (bnd) begin
      nxt = find_next(src_req, m_id);
      dw  = (m_dwell < 1) ? 1 : m_dwell;
      if ((m_hold == 0) || !src_req[2'(m_id)]) begin
        if (nxt >= 0) begin
          m_hold = 1; m_id = nxt; m_frames = 0; m_dwell = int'(dwell_cfg);
        end else m_hold = 0;
      end else if ((m_frames + 1 >= dw) && (nxt != m_id)) begin
        m_id = nxt; m_frames = 0; m_dwell = int'(dwell_cfg);
      end else begin
        m_frames = (m_frames + 1 > CNT_MAX) ? CNT_MAX : m_frames + 1;
      end
    end
    pulse = (m_hold != old_hold) || ((m_hold != 0) && (m_id != old_id));
    if (m_hold != 0) begin
      s  = m_id;
      d  = src_de[2'(s)];
      er = d ? src_rgb_r[s*DATA_W +: DATA_W] : 8'd0;
      eg = d ? src_rgb_g[s*DATA_W +: DATA_W] : 8'd0;
      eb = d ? src_rgb_b[s*DATA_W +: DATA_W] : 8'd0;
      exp_vec = {1'b1, 2'(m_id), pulse, src_hs[2'(s)], src_vs[2'(s)], d, er, eg, eb};
    end else begin
      exp_vec = {1'b0, 2'd0, pulse, src_hs[0], src_vs[0], 1'b0, 24'd0};
    end
  endtask

  task automatic step();
    @(posedge clk);
    vs_rise    = src_vs[0] && !tb_prev_vs;
    tb_prev_vs = src_vs[0];
    model_update();
    @(negedge clk);
    drive_timing();
  endtask

  task automatic hold_reset(input int n);
    arstn = 1'b0;
    repeat (n) step();
    for (int i = 0; i < 200 && vcnt != 2; i++) step();
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    src_req = 4'($urandom);
    repeat (4) begin
      step(); n_vec++;
      if (obs !== 31'd0) begin n_bad++; $display("FAIL reset_zero got=%h want=0", obs); end
      n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec); end
    end
  endtask

  task automatic test_first_grant();
    src_req = 4'b0001;
    dwell_cfg = 8'd1;
    for (int i = 0; i < 200 && vcnt != 2; i++) step();
    arstn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL first_model t=%0t got=%h want=%h", $time, obs, exp_vec); end
      if (vs_rise) break;
    end
    n_vec++;
    if (!(vs_rise && grant_valid === 1'b1 && grant_id === 2'd0 && switch_pulse === 1'b1)) begin
      n_bad++; $display("FAIL first_grant got v=%b id=%0d p=%b rise=%b want v=1 id=0 p=1 rise=1",
                        grant_valid, grant_id, switch_pulse, vs_rise);
    end
    repeat (40) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL first_rgb got=%h want=%h", obs, exp_vec); end
    end
  endtask

  task automatic test_dwell_rr();
    int ids[$];
    int gaps[$];
    int rises;
    int exp_ids[4] = '{0, 2, 0, 2};
    hold_reset(2);
    src_req = 4'b0101;
    dwell_cfg = 8'd3;
    rises = 0;
    for (int c = 0; c < 12 * H_TOT * V_TOT; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL dwell_model t=%0t got=%h want=%h", $time, obs, exp_vec); end
      if (vs_rise) rises++;
      if (switch_pulse) begin
        n_vec++;
        if (!vs_rise) begin n_bad++; $display("FAIL dwell_edge got rise=0 want rise=1"); end
        ids.push_back(int'(grant_id));
        gaps.push_back(rises);
        rises = 0;
      end
    end
    n_vec++;
    if (ids.size() < 4) begin n_bad++; $display("FAIL dwell_count got=%0d want>=4", ids.size()); end
    for (int i = 0; i < 4 && i < ids.size(); i++) begin
      n_vec++;
      if (ids[i] != exp_ids[i]) begin n_bad++; $display("FAIL dwell_seq[%0d] got=%0d want=%0d", i, ids[i], exp_ids[i]); end
      if (i > 0) begin
        n_vec++;
        if (gaps[i] != 3) begin n_bad++; $display("FAIL dwell_gap[%0d] got=%0d want=3", i, gaps[i]); end
      end
    end
  endtask

  task automatic test_drop();
    int rises;
    hold_reset(2);
    src_req = 4'b0001;
    dwell_cfg = 8'd10;
    for (int c = 0; c < 200; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL drop_model got=%h want=%h", obs, exp_vec); end
      if (switch_pulse) break;
    end
    n_vec++;
    if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin n_bad++; $display("FAIL drop_first got=%0d want=0", grant_id); end
    rises = 0;
    for (int c = 0; c < 300 && rises < 2; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL drop_model got=%h want=%h", obs, exp_vec); end
      if (vs_rise) rises++;
    end
    repeat (20) step();
    src_req = 4'b1000;
    for (int c = 0; c < 200; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL drop_model got=%h want=%h", obs, exp_vec); end
      if (vs_rise) rises++;
      if (switch_pulse) break;
    end
    n_vec++;
    if (!(switch_pulse && vs_rise && grant_id === 2'd3 && rises == 3)) begin
      n_bad++; $display("FAIL drop_switch got id=%0d frames=%0d p=%b want id=3 frames=3 p=1", grant_id, rises, switch_pulse);
    end
  endtask

  task automatic test_idle();
    int hs_edges, vs_edges;
    logic p_hs, p_vs;
    hold_reset(2);
    src_req = 4'b0010;
    dwell_cfg = 8'd0;
    for (int c = 0; c < 200; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL idle_model got=%h want=%h", obs, exp_vec); end
      if (switch_pulse) break;
    end
    n_vec++;
    if (grant_id !== 2'd1) begin n_bad++; $display("FAIL idle_grant got=%0d want=1", grant_id); end
    repeat (30) step();
    src_req = 4'b0000;
    for (int c = 0; c < 200; c++) begin
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL idle_model got=%h want=%h", obs, exp_vec); end
      if (switch_pulse) break;
    end
    n_vec++;
    if (!(vs_rise && switch_pulse && grant_valid === 1'b0)) begin
      n_bad++; $display("FAIL idle_enter got v=%b p=%b rise=%b want v=0 p=1 rise=1", grant_valid, switch_pulse, vs_rise);
    end
    hs_edges = 0; vs_edges = 0; p_hs = hs; p_vs = vs;
    repeat (H_TOT * V_TOT) begin
      step(); n_vec++;
      if (de !== 1'b0 || {rgb_r, rgb_g, rgb_b} !== 24'd0) begin
        n_bad++; $display("FAIL idle_black got de=%b rgb=%h want de=0 rgb=0", de, {rgb_r, rgb_g, rgb_b});
      end
      if (hs !== p_hs) hs_edges++;
      if (vs !== p_vs) vs_edges++;
      p_hs = hs; p_vs = vs;
    end
    n_vec++;
    if (hs_edges != 2 * V_TOT || vs_edges != 2) begin
      n_bad++; $display("FAIL idle_sync got hs=%0d vs=%0d want hs=%0d vs=2", hs_edges, vs_edges, 2 * V_TOT);
    end
  endtask

  task automatic test_midline();
    hold_reset(2);
    src_req = 4'b0010;
    dwell_cfg = 8'd1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (switch_pulse) break;
    end
    for (int c = 0; c < 100 && !(vcnt == 3 && hcnt == 6); c++) step();
    src_req = 4'b1010;
    repeat (5) begin
      step(); n_vec++;
      if (grant_id !== 2'd1 || switch_pulse !== 1'b0 || obs !== exp_vec) begin
        n_bad++; $display("FAIL mid_blip got id=%0d p=%b want id=1 p=0", grant_id, switch_pulse);
      end
    end
    src_req = 4'b0100;
    for (int c = 0; c < 200; c++) begin
      step();
      if (vs_rise) break;
      n_vec++;
      if (grant_id !== 2'd1 || switch_pulse !== 1'b0 || obs !== exp_vec) begin
        n_bad++; $display("FAIL mid_hold got=%h want=%h", obs, exp_vec);
      end
    end
    n_vec++;
    if (!(vs_rise && grant_id === 2'd2 && switch_pulse === 1'b1)) begin
      n_bad++; $display("FAIL mid_switch got id=%0d p=%b want id=2 p=1", grant_id, switch_pulse);
    end
  endtask

  task automatic test_reset_mid();
    hold_reset(2);
    src_req = 4'b0100;
    dwell_cfg = 8'd2;
    for (int c = 0; c < 200; c++) begin
      step();
      if (switch_pulse) break;
    end
    n_vec++;
    if (grant_id !== 2'd2) begin n_bad++; $display("FAIL rmid_grant got=%0d want=2", grant_id); end
    for (int c = 0; c < 100 && vcnt != 3; c++) step();
    arstn = 1'b0;
    step(); n_vec++;
    if (obs !== 31'd0) begin n_bad++; $display("FAIL rmid_zero got=%h want=0", obs); end
    arstn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (vs_rise) break;
      n_vec++;
      if (grant_valid !== 1'b0 || obs !== exp_vec) begin
        n_bad++; $display("FAIL rmid_wait got=%h want=%h", obs, exp_vec);
      end
    end
    n_vec++;
    if (!(vs_rise && grant_valid === 1'b1 && grant_id === 2'd2)) begin
      n_bad++; $display("FAIL rmid_regrant got v=%b id=%0d want v=1 id=2", grant_valid, grant_id);
    end
  endtask

  task automatic test_random();
    hold_reset(2);
    for (int c = 0; c < 40 * H_TOT * V_TOT; c++) begin
      if ($urandom_range(39, 0) == 0) src_req = 4'($urandom);
      if ($urandom_range(199, 0) == 0) dwell_cfg = 8'($urandom_range(4, 0));
      arstn = ($urandom_range(1499, 0) != 0);
      step(); n_vec++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL rand_model t=%0t got=%h want=%h", $time, obs, exp_vec); end
    end
    arstn = 1'b1;
  endtask

  initial begin
    drive_timing();
    test_reset();
    test_first_grant();
    test_dwell_rr();
    test_drop();
    test_idle();
    test_midline();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
